// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the Hack PC fetch/execute sequencer.
// PC_SEQ_SINGLE_STEP_EN adds the PAUSE state used for single-stepping.
package pc_seq_pkg;

  localparam int C_BIT   = 15;
  localparam int JMP_LSB = 0;
  localparam int JMP_W   = 3;
  localparam logic [JMP_W-1:0] JMP_ALWAYS = 3'b111;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_UPDATE,
`ifdef PC_SEQ_SINGLE_STEP_EN
    S_HALT,
    S_PAUSE
`else
    S_HALT
`endif
  } state_t;

endpackage

// File: rtl/jump_cond.sv
// Hack C-instruction jump evaluation from the jjj bits and ALU flags.
// Bit 2 = less-than, bit 1 = equal, bit 0 = greater-than.
module jump_cond
  import pc_seq_pkg::*;
(
  input  logic [JMP_W-1:0] jjj,
  input  logic             zr,
  input  logic             ng,
  output logic             jump
);

  assign jump = (jjj[2] & ng)
              | (jjj[1] & zr)
              | (jjj[0] & ~ng & ~zr);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/update controller for the Hack program counter.
// PC_SEQ_SINGLE_STEP_EN adds step_mode/step inputs and a PAUSE state.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
`ifdef PC_SEQ_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] instr,
  input  logic             alu_zr,
  input  logic             alu_ng,
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] pc_out,
  output logic             fetch_req,
  output logic             exec_en,
  output logic [WIDTH-1:0] instr_q,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             pc_reset,
  output logic             halted,
  output logic [WIDTH-1:0] retire_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(EXEC_CYCLES - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [JMP_W-1:0] jjj;
  logic             jump;
  logic             is_c;
  logic             take;
  logic             halt_hit;

  assign jjj      = instr_q[JMP_LSB +: JMP_W];
  assign is_c     = instr_q[C_BIT];
  assign take     = is_c & jump;
  assign halt_hit = is_c && (jjj == JMP_ALWAYS)
                 && (a_reg == pc_out);
  assign pc_in    = a_reg;

  // Live flags are used on the final EXEC cycle; the
  // result is registered into pc_load/pc_inc for UPDATE.
  jump_cond u_jump_cond (
    .jjj  (jjj),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .jump (jump)
  );

  always_comb begin
    state_d = state;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH:  if (instr_valid) state_d = S_EXEC;
        S_EXEC:   if (cnt == LAST) state_d = S_UPDATE;
        S_UPDATE: begin
          if (halt_hit) state_d = S_HALT;
`ifdef PC_SEQ_SINGLE_STEP_EN
          else if (step_mode) state_d = S_PAUSE;
`endif
          else state_d = S_FETCH;
        end
        S_HALT:   state_d = S_HALT;
`ifdef PC_SEQ_SINGLE_STEP_EN
        S_PAUSE:  if (step) state_d = S_FETCH;
`endif
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      instr_q    <= '0;
      retire_cnt <= '0;
      fetch_req  <= 1'b0;
      exec_en    <= 1'b0;
      pc_inc     <= 1'b0;
      pc_load    <= 1'b0;
      pc_reset   <= 1'b1;
      halted     <= 1'b0;
    end else begin
      state     <= state_d;
      fetch_req <= (state_d == S_FETCH);
      exec_en   <= (state_d == S_EXEC);
      pc_load   <= (state_d == S_UPDATE) & take;
      pc_inc    <= (state_d == S_UPDATE) & ~take;
      pc_reset  <= (state_d == S_IDLE);
      halted    <= (state_d == S_HALT);

      if (state == S_EXEC && state_d == S_EXEC)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;

      if (state == S_FETCH && state_d == S_EXEC)
        instr_q <= instr;

      if (state == S_IDLE)
        retire_cnt <= '0;
      else if (state == S_UPDATE)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule
